acoustic_cmd_fsm: RTL and testbench
===================================

# acoustic_cmd_fsm

Parametrised UART command sequencer for the acoustics FPGA, sitting between the UART RX/TX byte interfaces and the FFT/threshold datapath. It decodes single-byte opcodes and collects multi-byte arguments for the frequency and threshold registers. It streams multi-byte responses and scans NUM_CH channel trigger flags per FFT frame, with a built-in timeout counter. Compared with earlier controllers, this block supports a generic channel count and multi-byte arguments/responses, and reports which channel fired.

## Interface
Parameters:
- NUM_CH, 4: channels scanned per FFT frame (≥1).
- ARG_BYTES, 2: argument bytes per set command, MSB first (1..4); cfg_data width = 8*ARG_BYTES.
- TIMEOUT_W, 24: timer width.
- TIMEOUT_CYCLES, 10_000_000: timeout length in clk cycles; must be < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  UART TX can accept a byte.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  byte to transmit.
- fft_ready  in  1  one-cycle strobe, new FFT frame in RAM.
- ch_sel  out  max(1,$clog2(NUM_CH))  channel index driven to trigger RAM.
- trig_hit  in  1  threshold flag for ch_sel, valid one cycle after ch_sel.
- max_value  in  16  current peak magnitude.
- cfg_data  out  8*ARG_BYTES  assembled argument.
- freq_we  out  1  one-cycle frequency-register write.
- thresh_we  out  1  one-cycle threshold-register write.
- busy  out  1  high in every state except IDLE.

## Operation
- All outputs reset to 0. State resets to IDLE, and the timer, argument count and response buffer reset to 0.
- States are IDLE, DECODE, ARG, APPLY, SCAN_WAIT, SCAN_SEL, SCAN_CHK, TX_LOAD and TX_WAIT.
- IDLE: when rx_valid, latch rx_data and go to DECODE.
- DECODE acts on the low nibble of the latched byte:
  - 0xF: go to ARG, target freq.
  - 0x7: go to ARG, target thresh.
  - 0x4: load response {max_value[15:8], max_value[7:0]}, length 2, then go to TX_LOAD.
  - 0xD: clear timer, go to SCAN_WAIT.
  - Other values: go to IDLE (see Configuration).
- ARG:
  - Each rx_valid shifts the byte into cfg_data LSB end (left shift 8) and increments the count.
  - After ARG_BYTES bytes, go to APPLY.
  - Timer runs from ARG entry. On timeout, return to IDLE with no write strobe; cfg_data keeps its partial value.
- APPLY: pulse freq_we or thresh_we for one cycle with cfg_data stable, then go to IDLE.
- SCAN_WAIT: on fft_ready, set ch_sel=0 and go to SCAN_SEL.
- SCAN_SEL: one cycle for RAM latency, then go to SCAN_CHK.
- SCAN_CHK: sample trig_hit.
  - Hit: load response {0x54, ch_sel}, length 2, go to TX_LOAD.
  - Miss, ch_sel<NUM_CH-1: increment ch_sel, go to SCAN_SEL.
  - Miss on last channel: go to SCAN_WAIT.
- Lowest-index hitting channel wins.
- Timer runs continuously across SCAN_WAIT, SCAN_SEL and SCAN_CHK. On timeout, load response {0x46}, length 1, and go to TX_LOAD.
- If timeout and trig_hit coincide in SCAN_CHK, the hit wins.
- TX_LOAD: drive tx_valid=1 with the next buffer byte, go to TX_WAIT.
- TX_WAIT:
  - tx_valid and tx_data stay stable until a cycle with tx_valid && tx_ready, which consumes the byte.
  - If more bytes remain, go to TX_LOAD. Otherwise drop tx_valid and go to IDLE.
- rx_valid outside IDLE/ARG is ignored and the byte is dropped.
- Asynchronous reset mid-command: immediate return to IDLE. A partially sent response is abandoned and no write strobe is issued.

## Timing
- Timer: cleared on ARG/scan entry, increments each cycle. Timeout is declared in the cycle the count equals TIMEOUT_CYCLES-1, i.e. exactly TIMEOUT_CYCLES cycles after entry.
- rx_valid (opcode) to freq_we: 2 cycles (DECODE, ARG) plus argument arrival, plus 1 cycle APPLY.
- Opcode 0x4: tx_valid rises 3 cycles after the rx_valid edge (DECODE, TX_LOAD, registered).
- Scan: 2 cycles per channel, worst case 2*NUM_CH cycles per frame after fft_ready.
- fft_ready is ignored outside SCAN_WAIT.
- Minimum 1-cycle tx_valid gap between response bytes (TX_LOAD).

## Configuration
- ACOUSTIC_CMD_NAK_EN defined: an unknown opcode queues the single response 0x3F (NAK) through TX_LOAD/TX_WAIT.
- ACOUSTIC_CMD_NAK_EN undefined: an unknown opcode returns silently to IDLE with no TX activity.

## Test plan
- Reset, then rx 0xAF, 0x12, 0x34 (ARG_BYTES=2): cfg_data=0x1234, freq_we high exactly 1 cycle, thresh_we stays 0.
- rx 0x04 with max_value=0xBEEF and tx_ready held low for 5 cycles: tx_data stays 0xBE until the handshake, then 0xEF; no other tx bytes.
- rx 0x0D, fft_ready, trig_hit=1 only when ch_sel=2 (NUM_CH=4): response 0x54, 0x02; return to IDLE.
- rx 0x0D, never hit, TIMEOUT_CYCLES=100: exactly one byte 0x46, sent 100 cycles after scan entry.
- rx 0x07, one argument byte, then silence for TIMEOUT_CYCLES: no thresh_we, busy falls, next rx 0x04 is processed normally.
- rx 0x01: 0x3F sent with ACOUSTIC_CMD_NAK_EN; no tx_valid without it. Reset asserted mid-TX_WAIT clears tx_valid immediately.

Source files
------------

// File: rtl/acoustic_cmd_fsm.sv
// UART command sequencer: opcode decode, argument collection, channel trigger scan, byte responses.
// Define ACOUSTIC_CMD_NAK_EN to answer unknown opcodes with a single 0x3F byte.
module acoustic_cmd_fsm #(
    parameter int NUM_CH         = 4,
    parameter int ARG_BYTES      = 2,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CFG_W         = 8 * ARG_BYTES
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             fft_ready,
    output logic [CH_W-1:0]  ch_sel,
    input  logic             trig_hit,
    input  logic [15:0]      max_value,
    output logic [CFG_W-1:0] cfg_data,
    output logic             freq_we,
    output logic             thresh_we,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_ARG, S_APPLY, S_SCAN_WAIT,
        S_SCAN_SEL, S_SCAN_CHK, S_TX_LOAD, S_TX_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic                  tgt_q, tgt_d;        // 0: frequency, 1: threshold
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]  tmr_q, tmr_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [15:0]           rbuf_q, rbuf_d;
    logic [1:0]            rlen_q, rlen_d;
    logic                  txv_q, txv_d;
    logic [7:0]            txd_q, txd_d;
    logic                  tmo;

    assign tmo = (tmr_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tgt_q   <= 1'b0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            ch_q    <= '0;
            rbuf_q  <= '0;
            rlen_q  <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            ch_q    <= ch_d;
            rbuf_q  <= rbuf_d;
            rlen_q  <= rlen_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        ch_d    = ch_q;
        rbuf_d  = rbuf_q;
        rlen_d  = rlen_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    op_d    = rx_data[3:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_q)
                    4'hF, 4'h7: begin
                        tgt_d   = (op_q == 4'h7);
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = S_ARG;
                    end
                    4'h4: begin
                        rbuf_d  = max_value;
                        rlen_d  = 2'd2;
                        state_d = S_TX_LOAD;
                    end
                    4'hD: begin
                        tmr_d   = '0;
                        state_d = S_SCAN_WAIT;
                    end
                    default: begin
`ifdef ACOUSTIC_CMD_NAK_EN
                        rbuf_d  = 16'h3F00;
                        rlen_d  = 2'd1;
                        state_d = S_TX_LOAD;
`else
                        state_d = S_IDLE;
`endif
                    end
                endcase
            end
            S_ARG: begin
                tmr_d = tmr_q + 1'b1;
                if (rx_valid) begin
                    cfg_d = (cfg_q << 8) | CFG_W'(rx_data);
                    cnt_d = cnt_q + 1'b1;
                end
                // A final byte landing on the timeout cycle still completes the command
                if (rx_valid && cnt_q == 3'(ARG_BYTES - 1))
                    state_d = S_APPLY;
                else if (tmo)
                    state_d = S_IDLE;
            end
            S_APPLY: state_d = S_IDLE;
            S_SCAN_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (tmo) begin
                    rbuf_d  = 16'h4600;
                    rlen_d  = 2'd1;
                    state_d = S_TX_LOAD;
                end else if (fft_ready) begin
                    ch_d    = '0;
                    state_d = S_SCAN_SEL;
                end
            end
            S_SCAN_SEL: begin
                tmr_d = tmr_q + 1'b1;
                if (tmo) begin
                    rbuf_d  = 16'h4600;
                    rlen_d  = 2'd1;
                    state_d = S_TX_LOAD;
                end else begin
                    state_d = S_SCAN_CHK;
                end
            end
            S_SCAN_CHK: begin
                tmr_d = tmr_q + 1'b1;
                if (trig_hit) begin
                    rbuf_d  = {8'h54, 8'(ch_q)};
                    rlen_d  = 2'd2;
                    state_d = S_TX_LOAD;
                end else if (tmo) begin
                    rbuf_d  = 16'h4600;
                    rlen_d  = 2'd1;
                    state_d = S_TX_LOAD;
                end else if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_SCAN_WAIT;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_SCAN_SEL;
                end
            end
            S_TX_LOAD: begin
                txv_d   = 1'b1;
                txd_d   = rbuf_q[15:8];
                rbuf_d  = {rbuf_q[7:0], 8'h00};
                rlen_d  = rlen_q - 2'd1;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (txv_q && tx_ready) begin
                    txv_d   = 1'b0;
                    state_d = (rlen_q != 2'd0) ? S_TX_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_valid  = txv_q;
    assign tx_data   = txd_q;
    assign ch_sel    = ch_q;
    assign cfg_data  = cfg_q;
    assign freq_we   = (state_q == S_APPLY) && !tgt_q;
    assign thresh_we = (state_q == S_APPLY) && tgt_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_acoustic_cmd_fsm.sv
// Randomized bench for acoustic_cmd_fsm: commands are scored against expected byte streams,
// strobes and latencies computed from the command rules.
module tb_acoustic_cmd_fsm;
    localparam int NCH = 4;
    localparam int AB  = 2;
    localparam int TW  = 8;
    localparam int TC  = 100;

    logic        clk = 1'b0, reset_b = 1'b0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0, fft_ready = 1'b0, trig_hit = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] max_value = '0;
    logic        tx_valid, freq_we, thresh_we, busy;
    logic [7:0]  tx_data;
    logic [1:0]  ch_sel;
    logic [15:0] cfg_data;

    acoustic_cmd_fsm #(.NUM_CH(NCH), .ARG_BYTES(AB), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .reset_b(reset_b), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .fft_ready(fft_ready), .ch_sel(ch_sel), .trig_hit(trig_hit),
        .max_value(max_value), .cfg_data(cfg_data), .freq_we(freq_we),
        .thresh_we(thresh_we), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observed traffic
    logic [7:0]  txq[$];
    logic [15:0] fq[$], tq[$];
    int          rise_q[$];
    // expectations
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_fq[$], exp_tq[$];
    int          exp_rise = -1, t_ref = 0, t_op = 0;
    logic [15:0] cfg_m = '0;
    // environment controls
    int          hold_until = 0, rdy_pct = 70;
    logic [NCH-1:0] hit_mask = '0;
    bit          mon_en = 1'b1;

    // TX sink, trigger RAM and traffic monitor share the negedge
    initial begin : mon
        logic       prev_v, prev_r;
        logic [7:0] prev_d;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk);
            tx_ready = (cyc >= hold_until) && ($urandom_range(99) < rdy_pct);
            trig_hit = hit_mask[ch_sel];
            if (mon_en && reset_b) begin
                if (prev_v && !prev_r) begin
                    chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                    chk("tx_hold_data", 32'(tx_data), 32'(prev_d));
                end
                if (prev_v && prev_r) chk("tx_gap", 32'(tx_valid), 32'd0);
                if (tx_valid && !prev_v) rise_q.push_back(cyc);
                if (tx_valid && tx_ready) txq.push_back(tx_data);
                if (freq_we) fq.push_back(cfg_data);
                if (thresh_we) tq.push_back(cfg_data);
            end
            prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit is_op);
        @(negedge clk);
        if (is_op) t_op = cyc;
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic compare(input string tag);
        int k;
        k = 0;
        while (busy && k < 600) begin @(negedge clk); k++; end
        chk({tag, ".idle_timeout"}, 32'(k >= 600), 32'd0);
        idle(2);
        chk({tag, ".ntx"}, 32'(txq.size()), 32'(exp_tx.size()));
        for (int i = 0; i < txq.size() && i < exp_tx.size(); i++)
            chk({tag, ".tx"}, 32'(txq[i]), 32'(exp_tx[i]));
        chk({tag, ".nfreq"}, 32'(fq.size()), 32'(exp_fq.size()));
        for (int i = 0; i < fq.size() && i < exp_fq.size(); i++)
            chk({tag, ".freq"}, 32'(fq[i]), 32'(exp_fq[i]));
        chk({tag, ".nthr"}, 32'(tq.size()), 32'(exp_tq.size()));
        for (int i = 0; i < tq.size() && i < exp_tq.size(); i++)
            chk({tag, ".thr"}, 32'(tq[i]), 32'(exp_tq[i]));
        if (exp_rise >= 0)
            chk({tag, ".lat"}, 32'((rise_q.size() > 0) ? rise_q[0] - t_ref : -1), 32'(exp_rise));
        chk({tag, ".cfg"}, 32'(cfg_data), 32'(cfg_m));
        txq.delete(); fq.delete(); tq.delete(); rise_q.delete();
        exp_tx.delete(); exp_fq.delete(); exp_tq.delete();
        exp_rise = -1;
    endtask

    task automatic do_set(input bit th, input logic [15:0] val, input bit rnd_hi);
        logic [7:0] op;
        op = {rnd_hi ? 4'($urandom) : 4'hA, th ? 4'h7 : 4'hF};
        send(op, 1'b1);
        for (int i = AB - 1; i >= 0; i--) begin
            idle($urandom_range(0, 3));
            send(val[8*i +: 8], 1'b0);
        end
        cfg_m = val;
        if (th) exp_tq.push_back(val); else exp_fq.push_back(val);
        compare(th ? "set_thr" : "set_freq");
    endtask

    task automatic do_max(input logic [15:0] mv, input int hold);
        max_value = mv;
        hold_until = cyc + 3 + hold;
        send({4'($urandom), 4'h4}, 1'b1);
        t_ref = t_op; exp_rise = 3;
        exp_tx.push_back(mv[15:8]); exp_tx.push_back(mv[7:0]);
        compare("max");
    endtask

    task automatic do_scan(input logic [NCH-1:0] mask, input int dly);
        int idx;
        hit_mask = mask;
        @(negedge clk);
        t_op = cyc;
        rx_valid = 1'b1; rx_data = {4'($urandom), 4'hD};
        @(negedge clk);
        rx_data = 8'h0F;                     // stray byte while decoding must be dropped
        @(negedge clk);
        rx_valid = 1'b0;
        idle(dly);
        t_ref = cyc;
        fft_ready = 1'b1;
        @(negedge clk);
        fft_ready = 1'b0;
        idx = -1;
        for (int i = NCH - 1; i >= 0; i--) if (mask[i]) idx = i;
        if (idx >= 0) begin
            exp_tx.push_back(8'h54); exp_tx.push_back(8'(idx));
            exp_rise = 4 + 2 * idx;
        end else begin
            exp_tx.push_back(8'h46);
            t_ref = t_op; exp_rise = TC + 3;
        end
        compare(idx >= 0 ? "scan_hit" : "scan_to");
        hit_mask = '0;
    endtask

    task automatic do_arg_to(input bit th);
        logic [7:0] b;
        b = 8'($urandom);
        send({4'($urandom), th ? 4'h7 : 4'hF}, 1'b1);
        send(b, 1'b0);
        cfg_m = {cfg_m[7:0], b};
        while (cyc < t_op + TC + 1) @(negedge clk);
        chk("argto.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        chk("argto.busy_after", 32'(busy), 32'd0);
        compare("arg_to");
    endtask

    task automatic do_unk();
        logic [3:0] lo;
        do lo = 4'($urandom); while (lo == 4'hF || lo == 4'h7 || lo == 4'h4 || lo == 4'hD);
        send({4'($urandom), lo}, 1'b1);
`ifdef ACOUSTIC_CMD_NAK_EN
        exp_tx.push_back(8'h3F);
        t_ref = t_op; exp_rise = 3;
`endif
        compare("unknown");
    endtask

    initial begin
        idle(3);
        chk("rst.tx_valid", 32'(tx_valid), 32'd0);
        chk("rst.tx_data", 32'(tx_data), 32'd0);
        chk("rst.ch_sel", 32'(ch_sel), 32'd0);
        chk("rst.cfg", 32'(cfg_data), 32'd0);
        chk("rst.we", 32'({freq_we, thresh_we}), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        reset_b = 1'b1;
        idle(2);

        do_set(1'b0, 16'h1234, 1'b0);
        do_max(16'hBEEF, 5);
        do_scan(4'b0100, 0);
        do_scan(4'b0000, 1);
        do_arg_to(1'b1);
        do_max(16'h5A3C, 0);
        do_unk();

        repeat (40) begin
            case ($urandom_range(0, 5))
                0: do_set(1'b0, 16'($urandom), 1'b1);
                1: do_set(1'b1, 16'($urandom), 1'b1);
                2: do_max(16'($urandom), $urandom_range(0, 4));
                3: do_scan(4'($urandom), $urandom_range(0, 3));
                4: do_unk();
                default: do_arg_to(1'($urandom));
            endcase
        end

        // reset in the middle of a held response byte
        max_value = 16'hC0DE;
        hold_until = cyc + 1000;
        send(8'h04, 1'b1);
        idle(4);
        chk("rstmid.tx_valid_pre", 32'(tx_valid), 32'd1);
        mon_en = 1'b0;
        #2 reset_b = 1'b0;
        #1;
        chk("rstmid.tx_valid", 32'(tx_valid), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.we", 32'({freq_we, thresh_we}), 32'd0);
        idle(2);
        reset_b = 1'b1;
        hold_until = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
